// File: rtl/pipe_if_fetch.sv
// Instruction-fetch stage with IF/ID register, one-entry skid and delayed-branch redirect.
// Optional misaligned-fetch trap: define FETCH_ALIGN_CHECK_EN.
module pipe_if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic [2:0]  pc_select_i,
  input  logic [31:0] branch_addr_i,
  input  logic [31:0] jump_addr_i,
  input  logic [31:0] rs_addr_i,
  input  logic [31:0] cp0_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc4_o,
  output logic [31:0] instruction_o,
  output logic        valid_o,
  output logic        addr_err_o
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        rst_dly_q;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_tgt_q, redir_tgt_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        skid_err_q, skid_err_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic [31:0] pc_plus4;
  logic        misalign;
  logic        fetch_done;
  logic [31:0] fetch_word;
  logic        redirect;
  logic [31:0] target;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign    = (pc_q[1:0] != 2'b00);
  assign imem_addr_o = pc_q;
  assign fetch_done  = (state_q == FETCH) && !rst_dly_q && (misalign || imem_ready_i);
  assign fetch_word  = misalign ? 32'h0 : imem_rdata_i;
`else
  assign misalign    = 1'b0;
  assign imem_addr_o = {pc_q[31:2], 2'b00};
  assign fetch_done  = (state_q == FETCH) && !rst_dly_q && imem_ready_i;
  assign fetch_word  = imem_rdata_i;
`endif

  // No request in reset or in the release cycle, so a stray ready there is never consumed.
  assign imem_req_o = (state_q == FETCH) && !rst && !rst_dly_q && !misalign;

  // Redirect target; selects 5-7 behave as sequential.
  always_comb begin
    target   = pc_plus4;
    redirect = 1'b0;
    case (pc_select_i)
      3'd1: begin target = branch_addr_i; redirect = 1'b1; end
      3'd2: begin target = jump_addr_i;   redirect = 1'b1; end
      3'd3: begin target = rs_addr_i;     redirect = 1'b1; end
      3'd4: begin target = cp0_addr_i;    redirect = 1'b1; end
      default: ;
    endcase
    redirect = redirect && valid_q && !stall_i;
  end

  // Next-state, next-PC and IF/ID/skid updates.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    skid_pc4_d   = skid_pc4_q;
    skid_instr_d = skid_instr_q;
    skid_err_d   = skid_err_q;
    pc4_d        = pc4_q;
    instr_d      = instr_q;
    valid_d      = valid_q;
    err_d        = err_q;

    if (redirect && !fetch_done) begin
      redir_pend_d = 1'b1;
      redir_tgt_d  = target;
    end

    // The word completing now is the delay slot when a redirect is live or pending.
    if (fetch_done) begin
      redir_pend_d = 1'b0;
      if (redirect)          pc_d = target;
      else if (redir_pend_q) pc_d = redir_tgt_q;
      else                   pc_d = pc_plus4;
    end

    case (state_q)
      FETCH: begin
        if (!stall_i) begin
          if (fetch_done) begin
            pc4_d   = pc_plus4;
            instr_d = fetch_word;
            valid_d = 1'b1;
            err_d   = misalign;
          end else begin
            instr_d = 32'h0;
            valid_d = 1'b0;
            err_d   = 1'b0;
          end
        end else if (fetch_done) begin
          skid_pc4_d   = pc_plus4;
          skid_instr_d = fetch_word;
          skid_err_d   = misalign;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (!stall_i) begin
          pc4_d   = skid_pc4_q;
          instr_d = skid_instr_q;
          valid_d = 1'b1;
          err_d   = skid_err_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      rst_dly_q    <= 1'b1;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= 32'h0;
      skid_pc4_q   <= 32'h0;
      skid_instr_q <= 32'h0;
      skid_err_q   <= 1'b0;
      pc4_q        <= 32'h0;
      instr_q      <= 32'h0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rst_dly_q    <= 1'b0;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_err_q   <= skid_err_d;
      pc4_q        <= pc4_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign pc4_o         = pc4_q;
  assign instruction_o = instr_q;
  assign valid_o       = valid_q;
  assign addr_err_o    = err_q;

endmodule

// File: tb/tb_pipe_if_fetch.sv
// Directed-vector bench for pipe_if_fetch with a latency-programmable IMEM model.
module tb_pipe_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic [2:0]  pc_select_i = 3'd0;
  logic [31:0] branch_addr_i = 32'h0040_0100;
  logic [31:0] jump_addr_i   = 32'h0040_0200;
  logic [31:0] rs_addr_i     = 32'h0040_0300;
  logic [31:0] cp0_addr_i    = 32'h8000_0180;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc4_o;
  logic [31:0] instruction_o;
  logic        valid_o;
  logic        addr_err_o;

  int lat = 0;
  int wait_cnt = 0;
  logic force_ready = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  pipe_if_fetch dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .pc_select_i(pc_select_i),
    .branch_addr_i(branch_addr_i), .jump_addr_i(jump_addr_i),
    .rs_addr_i(rs_addr_i), .cp0_addr_i(cp0_addr_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i),
    .pc4_o(pc4_o), .instruction_o(instruction_o), .valid_o(valid_o),
    .addr_err_o(addr_err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {8'hC0, a[23:0]};
  endfunction

  // IMEM: ready after `lat` extra request cycles; force_ready injects a stray pulse.
  assign imem_ready_i = (imem_req_o && (wait_cnt == lat)) || force_ready;
  assign imem_rdata_i = instr_of(imem_addr_o);
  always @(posedge clk) wait_cnt <= (!imem_req_o || imem_ready_i) ? 0 : wait_cnt + 1;

  typedef struct {
    logic        stall;
    logic [2:0]  sel;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc4;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [2:0] sel, input logic req,
                              input logic [31:0] addr, input logic vld, input logic [31:0] pc4,
                              input logic [31:0] ins, input logic err);
    vec_t v;
    v.stall = st; v.sel = sel; v.exp_req = req; v.exp_addr = addr;
    v.exp_valid = vld; v.exp_pc4 = pc4; v.exp_instr = ins; v.exp_err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Starts at a negedge: drive, check fetch side, clock, check IF/ID side.
  task automatic step(input string tag, input vec_t v);
    stall_i = v.stall;
    pc_select_i = v.sel;
    #1;
    chk({tag, " req"},  32'(imem_req_o), 32'(v.exp_req));
    chk({tag, " addr"}, imem_addr_o, v.exp_addr);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " valid"}, 32'(valid_o), 32'(v.exp_valid));
    chk({tag, " pc4"},   pc4_o, v.exp_pc4);
    chk({tag, " instr"}, instruction_o, v.exp_instr);
    chk({tag, " err"},   32'(addr_err_o), 32'(v.exp_err));
  endtask

  // Asserts reset at a negedge, checks reset state, releases at the following negedge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    stall_i = 1'b0;
    pc_select_i = 3'd0;
    #1;
    chk({tag, " rst req"},   32'(imem_req_o), 32'd0);
    chk({tag, " rst addr"},  imem_addr_o, 32'h0040_0000);
    chk({tag, " rst valid"}, 32'(valid_o), 32'd0);
    chk({tag, " rst pc4"},   pc4_o, 32'h0);
    chk({tag, " rst instr"}, instruction_o, 32'h0);
    chk({tag, " rst err"},   32'(addr_err_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl[18];

  initial begin
    // Zero-wait stream, stall/skid, branch/jump/cp0 redirects, select 5 ignored.
    tbl[0]  = mk(0, 0, 0, 32'h0040_0000, 0, 32'h0,         32'h0,                   0);
    tbl[1]  = mk(0, 0, 1, 32'h0040_0000, 1, 32'h0040_0004, instr_of(32'h0040_0000), 0);
    tbl[2]  = mk(0, 0, 1, 32'h0040_0004, 1, 32'h0040_0008, instr_of(32'h0040_0004), 0);
    tbl[3]  = mk(0, 0, 1, 32'h0040_0008, 1, 32'h0040_000C, instr_of(32'h0040_0008), 0);
    tbl[4]  = mk(0, 0, 1, 32'h0040_000C, 1, 32'h0040_0010, instr_of(32'h0040_000C), 0);
    tbl[5]  = mk(1, 0, 1, 32'h0040_0010, 1, 32'h0040_0010, instr_of(32'h0040_000C), 0);
    tbl[6]  = mk(1, 0, 0, 32'h0040_0014, 1, 32'h0040_0010, instr_of(32'h0040_000C), 0);
    tbl[7]  = mk(0, 0, 0, 32'h0040_0014, 1, 32'h0040_0014, instr_of(32'h0040_0010), 0);
    tbl[8]  = mk(0, 0, 1, 32'h0040_0014, 1, 32'h0040_0018, instr_of(32'h0040_0014), 0);
    tbl[9]  = mk(0, 1, 1, 32'h0040_0018, 1, 32'h0040_001C, instr_of(32'h0040_0018), 0);
    tbl[10] = mk(0, 0, 1, 32'h0040_0100, 1, 32'h0040_0104, instr_of(32'h0040_0100), 0);
    tbl[11] = mk(0, 2, 1, 32'h0040_0104, 1, 32'h0040_0108, instr_of(32'h0040_0104), 0);
    tbl[12] = mk(0, 5, 1, 32'h0040_0200, 1, 32'h0040_0204, instr_of(32'h0040_0200), 0);
    tbl[13] = mk(1, 3, 1, 32'h0040_0204, 1, 32'h0040_0204, instr_of(32'h0040_0200), 0);
    tbl[14] = mk(0, 0, 0, 32'h0040_0208, 1, 32'h0040_0208, instr_of(32'h0040_0204), 0);
    tbl[15] = mk(0, 0, 1, 32'h0040_0208, 1, 32'h0040_020C, instr_of(32'h0040_0208), 0);
    tbl[16] = mk(0, 4, 1, 32'h0040_020C, 1, 32'h0040_0210, instr_of(32'h0040_020C), 0);
    tbl[17] = mk(0, 0, 1, 32'h8000_0180, 1, 32'h8000_0184, instr_of(32'h8000_0180), 0);

    @(negedge clk);
    do_reset("init");
    for (int i = 0; i < 18; i++) step($sformatf("tbl%0d", i), tbl[i]);

    // Slow IMEM: two bubbles, address held, select ignored while IF/ID invalid.
    do_reset("slow");
    lat = 2;
    step("slow0", mk(0, 0, 0, 32'h0040_0000, 0, 32'h0, 32'h0, 0));
    step("slow1", mk(0, 1, 1, 32'h0040_0000, 0, 32'h0, 32'h0, 0));
    step("slow2", mk(0, 1, 1, 32'h0040_0000, 0, 32'h0, 32'h0, 0));
    step("slow3", mk(0, 0, 1, 32'h0040_0000, 1, 32'h0040_0004, instr_of(32'h0040_0000), 0));

    // Branch while delay slot is still in flight: pending redirect.
    lat = 1;
    step("pend0", mk(0, 1, 1, 32'h0040_0004, 0, 32'h0040_0004, 32'h0, 0));
    step("pend1", mk(0, 2, 1, 32'h0040_0004, 1, 32'h0040_0008, instr_of(32'h0040_0004), 0));
    step("pend2", mk(0, 0, 1, 32'h0040_0100, 0, 32'h0040_0008, 32'h0, 0));
    step("pend3", mk(0, 0, 1, 32'h0040_0100, 1, 32'h0040_0104, instr_of(32'h0040_0100), 0));

    // Reset mid-wait at pc 0x00400020, stray ready in the release cycle.
    jump_addr_i = 32'h0040_0020;
    lat = 0;
    step("mid0", mk(0, 2, 1, 32'h0040_0104, 1, 32'h0040_0108, instr_of(32'h0040_0104), 0));
    lat = 3;
    step("mid1", mk(0, 0, 1, 32'h0040_0020, 0, 32'h0040_0108, 32'h0, 0));
    do_reset("mid");
    force_ready = 1'b1;
    step("mid2", mk(0, 0, 0, 32'h0040_0000, 0, 32'h0, 32'h0, 0));
    force_ready = 1'b0;
    lat = 0;
    step("mid3", mk(0, 0, 1, 32'h0040_0000, 1, 32'h0040_0004, instr_of(32'h0040_0000), 0));

    // PC wrap at the top of the address space.
    jump_addr_i = 32'hFFFF_FFFC;
    step("wrap0", mk(0, 2, 1, 32'h0040_0004, 1, 32'h0040_0008, instr_of(32'h0040_0004), 0));
    step("wrap1", mk(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h0000_0000, instr_of(32'hFFFF_FFFC), 0));
    step("wrap2", mk(0, 0, 1, 32'h0000_0000, 1, 32'h0000_0004, instr_of(32'h0000_0000), 0));

    // jr to a misaligned target.
    rs_addr_i = 32'h0040_0002;
    step("algn0", mk(0, 3, 1, 32'h0000_0004, 1, 32'h0000_0008, instr_of(32'h0000_0004), 0));
`ifdef FETCH_ALIGN_CHECK_EN
    step("algn1", mk(0, 0, 0, 32'h0040_0002, 1, 32'h0040_0006, 32'h0, 1));
    step("algn2", mk(0, 0, 0, 32'h0040_0006, 1, 32'h0040_000A, 32'h0, 1));
`else
    step("algn1", mk(0, 0, 1, 32'h0040_0000, 1, 32'h0040_0006, instr_of(32'h0040_0000), 0));
    step("algn2", mk(0, 0, 1, 32'h0040_0004, 1, 32'h0040_000A, instr_of(32'h0040_0004), 0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
